i2c_req_arbiter: RTL and testbench
==================================

// Module: i2c_req_arbiter
// PURPOSE
//  Shares one I2C byte-transaction master (and its SCL divider speed select) between NREQ on-chip
//  requesters, e.g. MPU6050 pose reader and PCF8591 DAC writer. Round-robin grant, one transaction
//  per grant, bus-free gap between transactions, watchdog abort on a hung master.
// PARAMETERS
//  NREQ      2      number of requesters (2..8)
//  GAP_CYC   600    clk cycles idle between consecutive transactions (>= t_BUF at 12 MHz)
//  TMO_CYC   120000 watchdog: max clk cycles from m_start to m_done (10 ms @ 12 MHz)
//  CW        17     width of the shared gap/watchdog counter; 2**CW > max(GAP_CYC,TMO_CYC)
// PORTS
//  clk        in   1        system clock (12 MHz board clock)
//  rst        in   1        asynchronous, active-high reset
//  req        in   NREQ     level request; held high until that requester's done pulse
//  req_fast   in   NREQ     per-requester speed: 1 = 400 kHz, 0 = 100 kHz
//  req_rd     in   NREQ     1 = read byte, 0 = write byte
//  req_dev    in   7*NREQ   7-bit device address, slice i = requester i
//  req_reg    in   8*NREQ   register address
//  req_wdata  in   8*NREQ   write data
//  gnt        out  NREQ     one-hot grant, held for the whole transaction
//  done       out  NREQ     one-cycle completion pulse to the granted requester
//  err        out  1        valid with done: 1 = NACK or watchdog abort
//  rdata      out  8        read byte, valid with done (0 for writes and aborts)
//  m_start    out  1        one-cycle start pulse to the I2C master
//  m_rd, m_dev, m_reg, m_wdata  out 1/7/8/8  transaction fields, stable from m_start to m_done
//  m_fast     out  1        divider select (N=30 when 1, N=120 when 0); changes only in IDLE/GAP
//  m_abort    out  1        one-cycle pulse forcing master to stop/idle
//  m_busy     in   1        master busy
//  m_done     in   1        one-cycle completion pulse from master
//  m_nack     in   1        NACK flag, valid with m_done
//  m_rdata    in   8        read byte, valid with m_done
// BEHAVIOUR
//  - Reset: FSM=IDLE, gnt=0, done=0, err=0, rdata=0, m_start=0, m_abort=0, m_rd=0, m_dev=0, m_reg=0,
//    m_wdata=0, m_fast=0, rr pointer=0, counter=0. All outputs registered.
//  - FSM: IDLE -> LAUNCH -> WAIT -> FINISH -> GAP -> IDLE.
//    IDLE: if any req and !m_busy, pick first set req at or after rr pointer (wrapping NREQ-1->0);
//      register gnt, m_* fields, m_fast from that slice; -> LAUNCH. No req: stay.
//    LAUNCH: m_start=1 for exactly one cycle; counter cleared; -> WAIT.
//    WAIT: counter++ each cycle. On m_done: latch err=m_nack, rdata=m_rd&&!m_nack ? m_rdata : 0; -> FINISH.
//      If counter reaches TMO_CYC-1 without m_done: m_abort=1 one cycle, err=1, rdata=0; -> FINISH.
//      m_done and timeout in the same cycle: m_done wins, no abort.
//    FINISH: done[granted]=1 for one cycle; rr pointer = granted index + 1 (mod NREQ); gnt cleared
//      on exit; counter cleared; -> GAP.
//    GAP: counter++ ; at GAP_CYC-1 -> IDLE. Requests arriving meanwhile wait (no loss).
//  - Latency: req (in IDLE, bus free) -> m_start = 2 clk; m_done -> done = 2 clk.
//  - Requester dropping req while granted is ignored; transaction completes, done still pulses.
//  - Fields are sampled only in IDLE; changes during a transaction have no effect.
//  - m_busy high in IDLE (external/previous master activity) blocks arbitration.
//  - Stray m_done outside WAIT is ignored.
//  - Async rst mid-transaction: all outputs return to reset values immediately; no done pulse;
//    master is reset by the same rst.
//  - Starvation-free: with all requesters continuously requesting, grants rotate 0,1,..,NREQ-1.
// STRUCTURE
//  - Shared package i2c_pkg: state encodings (ST_IDLE..ST_GAP), I2C_ADDR_W=7, I2C_DATA_W=8,
//    SPEED_100K=0 / SPEED_400K=1, divider constants N_100K=120, N_400K=30.
//  - One natural sub-module: rr_pick (combinational round-robin selector: req, ptr -> one-hot, index).
//  - Single counter shared by WAIT watchdog and GAP timer.
// TESTING
//  1 Single write: req[1]=1, dev=0x48, reg=0x40, wdata=0xA5, fast=0 -> gnt=2'b10, m_start 2 clk later
//    with fields equal, m_fast=0; model m_done nack=0 -> done[1] pulse, err=0, rdata=0.
//  2 Read: req[0], rd=1, dev=0x68, reg=0x3B, fast=1 -> m_fast=1; m_done with m_rdata=0x7F ->
//    done[0], rdata=0x7F, err=0; next m_start not before GAP_CYC cycles after done.
//  3 Contention: req=2'b11 held -> grants alternate 0,1,0,1 over 4 transactions; simultaneous
//    req from reset picks 0 first.
//  4 NACK: m_done with m_nack=1 on a read -> err=1, rdata=0, done pulse, no m_abort.
//  5 Hang: never assert m_done -> m_abort pulse exactly TMO_CYC cycles after m_start, err=1,
//    done pulse; m_done in same cycle as timeout -> no abort, err=m_nack.
//  6 rst asserted during WAIT -> gnt, m_start, done all 0 same cycle; after release single req
//    is served normally by requester 0 priority.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared constants for the I2C request arbiter: field widths, speed codes,
// divider values and the arbiter FSM state encodings.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  localparam logic SPEED_100K = 1'b0;
  localparam logic SPEED_400K = 1'b1;

  localparam int N_100K = 120;
  localparam int N_400K = 30;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_FINISH = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;

  // SCL divider ratio the master uses for a given speed select
  function automatic int div_n(input logic fast);
    return (fast == SPEED_400K) ? N_400K : N_100K;
  endfunction

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Link between the arbiter and the shared I2C byte-transaction master.
//
// Handshake: the arbiter pulses m_start for one cycle with m_rd/m_dev/m_reg/
// m_wdata already valid, and holds those fields stable until the master
// answers with a one-cycle m_done (m_nack and m_rdata valid in that same
// cycle). A one-cycle m_abort tells the master to stop and go idle; no
// m_done is expected afterwards. m_busy is a level the master raises while
// it is driving the bus. m_fast only changes while no transaction is open.
interface i2c_req_arbiter_if;
  import i2c_pkg::*;

  logic                  m_start;
  logic                  m_rd;
  logic [I2C_ADDR_W-1:0] m_dev;
  logic [I2C_DATA_W-1:0] m_reg;
  logic [I2C_DATA_W-1:0] m_wdata;
  logic                  m_fast;
  logic                  m_abort;
  logic                  m_busy;
  logic                  m_done;
  logic                  m_nack;
  logic [I2C_DATA_W-1:0] m_rdata;

  // arbiter side
  modport master (
    output m_start, m_rd, m_dev, m_reg, m_wdata, m_fast, m_abort,
    input  m_busy, m_done, m_nack, m_rdata
  );

  // I2C byte engine side
  modport slave (
    input  m_start, m_rd, m_dev, m_reg, m_wdata, m_fast, m_abort,
    output m_busy, m_done, m_nack, m_rdata
  );

endinterface

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            any
);

  // scan from farthest to nearest so the nearest set request wins
  always_comb begin
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = PW'(j);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C byte master between NREQ requesters: round-robin grant,
// one transaction per grant, fixed idle gap between transactions and a
// watchdog that aborts a master that never reports completion.
module i2c_req_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int GAP_CYC = 600,
  parameter int TMO_CYC = 120000,
  parameter int CW      = 17
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_fast,
  input  logic [NREQ-1:0]            req_rd,
  input  logic [I2C_ADDR_W*NREQ-1:0] req_dev,
  input  logic [I2C_DATA_W*NREQ-1:0] req_reg,
  input  logic [I2C_DATA_W*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            done,
  output logic                       err,
  output logic [I2C_DATA_W-1:0]      rdata,
  i2c_req_arbiter_if.master          mif,
  output logic [2:0]                 dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(NREQ - 1);

  logic [2:0]      state;
  logic [CW-1:0]   cnt;     // watchdog in WAIT, gap timer in GAP
  logic [PW-1:0]   ptr;     // round-robin start point
  logic [PW-1:0]   gidx;    // index of the granted requester
  logic [NREQ-1:0] pick_oh;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign dbg_state = state;

  // arbitration FSM; every output is a register, pulses default low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ptr         <= '0;
      gidx        <= '0;
      gnt         <= '0;
      done        <= '0;
      err         <= 1'b0;
      rdata       <= '0;
      mif.m_start <= 1'b0;
      mif.m_abort <= 1'b0;
      mif.m_rd    <= 1'b0;
      mif.m_dev   <= '0;
      mif.m_reg   <= '0;
      mif.m_wdata <= '0;
      mif.m_fast  <= 1'b0;
    end else begin
      mif.m_start <= 1'b0;
      mif.m_abort <= 1'b0;
      done        <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_any && !mif.m_busy) begin
            gnt         <= pick_oh;
            gidx        <= pick_idx;
            mif.m_rd    <= req_rd[pick_idx];
            mif.m_fast  <= req_fast[pick_idx];
            mif.m_dev   <= req_dev[int'(pick_idx)*I2C_ADDR_W +: I2C_ADDR_W];
            mif.m_reg   <= req_reg[int'(pick_idx)*I2C_DATA_W +: I2C_DATA_W];
            mif.m_wdata <= req_wdata[int'(pick_idx)*I2C_DATA_W +: I2C_DATA_W];
            state       <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          mif.m_start <= 1'b1;
          cnt         <= '0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          // a completion in the timeout cycle still counts as a completion
          if (mif.m_done) begin
            err   <= mif.m_nack;
            rdata <= (mif.m_rd && !mif.m_nack) ? mif.m_rdata : '0;
            state <= ST_FINISH;
          end else if (cnt == TMO_LAST) begin
            mif.m_abort <= 1'b1;
            err         <= 1'b1;
            rdata       <= '0;
            state       <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          done  <= gnt;
          gnt   <= '0;
          ptr   <= (gidx == IDX_LAST) ? '0 : gidx + 1'b1;
          cnt   <= '0;
          state <= ST_GAP;
        end
        ST_GAP: begin
          cnt <= cnt + 1'b1;
          if (cnt == GAP_LAST) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed and randomized bench for i2c_req_arbiter with a small-parameter
// instance (short gap and watchdog) and a round-robin reference model.
module tb_i2c_req_arbiter;

  localparam int NREQ = 2;
  localparam int GAP  = 20;
  localparam int TMO  = 200;
  localparam int CW   = 17;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req, req_fast, req_rd;
  logic [7*NREQ-1:0] req_dev;
  logic [8*NREQ-1:0] req_reg, req_wdata;
  logic [NREQ-1:0] gnt, done;
  logic            err;
  logic [7:0]      rdata;
  logic [2:0]      dbg_state;

  i2c_req_arbiter_if mif();

  i2c_req_arbiter #(.NREQ(NREQ), .GAP_CYC(GAP), .TMO_CYC(TMO), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_fast  (req_fast),
    .req_rd    (req_rd),
    .req_dev   (req_dev),
    .req_reg   (req_reg),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mif       (mif),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int abort_cnt = 0;
  int start_cnt = 0;
  int done_cyc = 0;
  int model_ptr = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mif.m_abort === 1'b1) abort_cnt <= abort_cnt + 1;
    if (mif.m_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // reference: first requester at or after the pointer, wrapping
  function automatic int model_pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++)
      if (r[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
    return 0;
  endfunction

  task automatic set_fields(input int i, input logic rd, input logic fast,
                            input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    req_rd[i]          = rd;
    req_fast[i]        = fast;
    req_dev[i*7 +: 7]  = dev;
    req_reg[i*8 +: 8]  = rg;
    req_wdata[i*8 +: 8] = wd;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < NREQ; i++)
      set_fields(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 7'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mode 0: normal completion, 1: hung master, 2: m_done in the timeout cycle
  // exp_lat >= 0: req->m_start latency; -2: check gap from previous done
  task automatic txn(input logic [NREQ-1:0] reqv, input int mode, input bit nack,
                     input logic [7:0] mbyte, input bit hold, input bit drop, input int exp_lat);
    int w, n, ab0;
    logic       e_rd, e_fast, e_err;
    logic [6:0] e_dev;
    logic [7:0] e_reg, e_wd, e_rdata;
    w      = model_pick(reqv);
    req    = reqv;
    e_rd   = req_rd[w];
    e_fast = req_fast[w];
    e_dev  = req_dev[w*7 +: 7];
    e_reg  = req_reg[w*8 +: 8];
    e_wd   = req_wdata[w*8 +: 8];
    n = 0;
    while (n < GAP + 20) begin
      @(negedge clk);
      n++;
      if (mif.m_start === 1'b1) break;
    end
    chk("start_seen", 32'(mif.m_start), 32'd1);
    if (exp_lat >= 0) chk("start_lat", n, exp_lat);
    if (exp_lat == -2) chk("gap_len", cyc - done_cyc, GAP + 2);
    chk("gnt", 32'(gnt), 32'(1) << w);
    chk("m_rd", 32'(mif.m_rd), 32'(e_rd));
    chk("m_fast", 32'(mif.m_fast), 32'(e_fast));
    chk("m_dev", 32'(mif.m_dev), 32'(e_dev));
    chk("m_reg", 32'(mif.m_reg), 32'(e_reg));
    chk("m_wdata", 32'(mif.m_wdata), 32'(e_wd));
    if (drop) req[w] = 1'b0;
    rand_fields();
    ab0 = abort_cnt;
    if (mode == 1) begin
      n = 0;
      while (n < TMO + 10) begin
        @(negedge clk);
        n++;
        if (mif.m_abort === 1'b1) break;
      end
      chk("abort_lat", n, TMO);
      @(negedge clk);
      e_err = 1'b1;
      e_rdata = 8'h00;
    end else begin
      if (mode == 2) repeat (TMO - 1) @(negedge clk);
      else repeat ($urandom_range(1, 8)) @(negedge clk);
      mif.m_done = 1'b1;
      mif.m_nack = nack;
      mif.m_rdata = mbyte;
      @(negedge clk);
      mif.m_done = 1'b0;
      chk("done_early", 32'(done), 32'd0);
      if (mode == 2) chk("no_abort_tmo", 32'(mif.m_abort), 32'd0);
      @(negedge clk);
      chk("abort_none", abort_cnt, ab0);
      e_err = nack;
      e_rdata = (e_rd && !nack) ? mbyte : 8'h00;
    end
    chk("done", 32'(done), 32'(1) << w);
    chk("err", 32'(err), 32'(e_err));
    chk("rdata", 32'(rdata), 32'(e_rdata));
    chk("gnt_clr", 32'(gnt), 32'd0);
    chk("hold_dev", 32'(mif.m_dev), 32'(e_dev));
    done_cyc = cyc;
    model_ptr = (w + 1) % NREQ;
    if (!hold) req[w] = 1'b0;
    @(negedge clk);
    chk("done_once", 32'(done), 32'd0);
  endtask

  initial begin
    int s0;
    rst = 1'b1;
    req = '0;
    req_fast = '0;
    req_rd = '0;
    req_dev = '0;
    req_reg = '0;
    req_wdata = '0;
    mif.m_busy = 1'b0;
    mif.m_done = 1'b0;
    mif.m_nack = 1'b0;
    mif.m_rdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_m_start", 32'(mif.m_start), 32'd0);
    chk("rst_m_abort", 32'(mif.m_abort), 32'd0);
    chk("rst_m_dev", 32'(mif.m_dev), 32'd0);
    chk("rst_m_fast", 32'(mif.m_fast), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // contention from reset: 0,1,0,1
    rand_fields();
    txn(2'b11, 0, 1'b0, 8'($urandom), 1'b1, 1'b0, 2);
    txn(2'b11, 0, 1'b0, 8'($urandom), 1'b1, 1'b0, -2);
    txn(2'b11, 0, 1'b0, 8'($urandom), 1'b1, 1'b0, -2);
    txn(2'b11, 0, 1'b0, 8'($urandom), 1'b1, 1'b0, -2);
    req = '0;
    idle_wait(GAP + 4);

    // single write on requester 1
    set_fields(1, 1'b0, 1'b0, 7'h48, 8'h40, 8'hA5);
    txn(2'b10, 0, 1'b0, 8'h5A, 1'b0, 1'b0, 2);
    idle_wait(GAP + 4);

    // read on requester 0 at 400 kHz, then a request raised during the gap
    set_fields(0, 1'b1, 1'b1, 7'h68, 8'h3B, 8'h11);
    txn(2'b01, 0, 1'b0, 8'h7F, 1'b0, 1'b0, 2);
    txn(2'b10, 0, 1'b0, 8'($urandom), 1'b0, 1'b0, -2);
    idle_wait(GAP + 4);

    // NACK on a read
    set_fields(0, 1'b1, 1'b0, 7'h68, 8'h75, 8'h00);
    txn(2'b01, 0, 1'b1, 8'h33, 1'b0, 1'b0, 2);
    idle_wait(GAP + 4);

    // hung master, then m_done exactly in the timeout cycle
    txn(2'b10, 1, 1'b0, 8'h00, 1'b0, 1'b0, 2);
    idle_wait(GAP + 4);
    set_fields(0, 1'b1, 1'b1, 7'h68, 8'h3B, 8'h00);
    txn(2'b01, 2, 1'b0, 8'h44, 1'b0, 1'b0, 2);
    idle_wait(GAP + 4);
    txn(2'b10, 2, 1'b1, 8'h44, 1'b0, 1'b0, 2);
    idle_wait(GAP + 4);

    // requester drops req while granted
    rand_fields();
    txn(2'b01, 0, 1'b0, 8'($urandom), 1'b0, 1'b1, 2);
    idle_wait(GAP + 4);

    // m_busy blocks arbitration
    mif.m_busy = 1'b1;
    req = 2'b10;
    s0 = start_cnt;
    idle_wait(6);
    chk("busy_gnt", 32'(gnt), 32'd0);
    chk("busy_start", start_cnt, s0);
    mif.m_busy = 1'b0;
    txn(2'b10, 0, 1'b0, 8'($urandom), 1'b0, 1'b0, 2);
    idle_wait(GAP + 4);

    // stray m_done while idle
    mif.m_done = 1'b1;
    mif.m_nack = 1'b1;
    @(negedge clk);
    mif.m_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_done", 32'(done), 32'd0);
    end

    // randomized traffic
    for (int i = 0; i < 10; i++) begin
      rand_fields();
      txn(2'($urandom_range(1, 3)), 0, 1'($urandom_range(0, 1)), 8'($urandom),
          1'b0, 1'($urandom_range(0, 1)), -1);
    end
    req = '0;
    idle_wait(GAP + 4);

    // reset in WAIT: pointer must return to requester 0
    rand_fields();
    txn(2'b01, 0, 1'b0, 8'($urandom), 1'b0, 1'b0, 2);
    idle_wait(GAP + 4);
    req = 2'b10;
    idle_wait(5);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_m_start", 32'(mif.m_start), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_m_dev", 32'(mif.m_dev), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    model_ptr = 0;
    idle_wait(2);
    txn(2'b11, 0, 1'b0, 8'($urandom), 1'b0, 1'b0, 2);
    req = '0;
    idle_wait(GAP + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
